// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg: shared state encoding and default widths for the Horner evaluator
package poly_eval_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int DEG_W_DEF  = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MAC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/horner_mac.sv
// horner_mac: one Horner step next_acc = acc*x + c mod 2^DATA_W; ovf_step exists under HORNER_OVERFLOW_DETECT_EN
module horner_mac #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] next_acc
`ifdef HORNER_OVERFLOW_DETECT_EN
    ,
    output logic              ovf_step
`endif
);
`ifdef HORNER_OVERFLOW_DETECT_EN
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     sum;
    assign prod     = acc * x;
    assign sum      = {1'b0, prod[DATA_W-1:0]} + {1'b0, c};
    assign next_acc = sum[DATA_W-1:0];
    assign ovf_step = |prod[2*DATA_W-1:DATA_W] | sum[DATA_W];
`else
    assign next_acc = acc * x + c;
`endif
endmodule

// File: rtl/horner_evaluator.sv
// horner_evaluator: sequential Horner polynomial evaluator over an external synchronous ROM; HORNER_OVERFLOW_DETECT_EN enables sticky ovf
module horner_evaluator
    import poly_eval_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEG_W  = DEG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DEG_W-1:0]  degree,
    input  logic [DATA_W-1:0] x,
    output logic              coef_rd,
    output logic [DEG_W-1:0]  coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);
    state_t            state, nxt;
    logic [DATA_W-1:0] x_q, acc, next_acc;
    logic [DEG_W-1:0]  idx, idx_nxt;
    logic              accept, last;

    assign accept = state == ST_IDLE && start;
    assign last   = idx == '0;

`ifdef HORNER_OVERFLOW_DETECT_EN
    logic ovf_step;
    horner_mac #(.DATA_W(DATA_W)) u_mac (
        .acc(acc), .x(x_q), .c(coef_data), .next_acc(next_acc), .ovf_step(ovf_step)
    );
    // sticky overflow, cleared when a new evaluation is accepted
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            ovf <= 1'b0;
        else if (accept)
            ovf <= 1'b0;
        else if (state == ST_MAC && ovf_step)
            ovf <= 1'b1;
`else
    horner_mac #(.DATA_W(DATA_W)) u_mac (
        .acc(acc), .x(x_q), .c(coef_data), .next_acc(next_acc)
    );
    assign ovf = 1'b0;
`endif

    // state register plus operand/accumulator/result datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            x_q    <= '0;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            state <= nxt;
            idx   <= idx_nxt;
            if (accept) begin
                x_q <= x;
                acc <= '0;
            end
            if (state == ST_MAC)
                acc <= next_acc;
            if (state == ST_MAC && last)
                result <= next_acc;
        end
    end

    // next state and next coefficient index
    always_comb begin
        nxt = state == ST_IDLE  ? (start ? ST_FETCH : ST_IDLE) :
              state == ST_FETCH ? ST_MAC :
              state == ST_MAC   ? (last ? ST_DONE : ST_FETCH) : ST_IDLE;
        idx_nxt = accept ? degree : (state == ST_MAC && !last) ? idx - 1'b1 : idx;
    end

    // outputs registered from the upcoming state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            coef_rd   <= 1'b0;
            coef_addr <= '0;
        end else begin
            busy      <= nxt == ST_FETCH || nxt == ST_MAC;
            done      <= nxt == ST_DONE;
            coef_rd   <= nxt == ST_FETCH;
            coef_addr <= idx_nxt;
        end
    end
endmodule

// File: tb/tb_horner_evaluator.sv
// tb_horner_evaluator: randomized and directed checks of horner_evaluator against a plain-arithmetic polynomial model
module tb_horner_evaluator;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [3:0]  degree = '0;
    logic [15:0] x = '0, coef_data = '0;
    logic        coef_rd, busy, done, ovf;
    logic [3:0]  coef_addr;
    logic [15:0] result;

    horner_evaluator dut (
        .clk(clk), .reset(reset), .start(start), .degree(degree), .x(x),
        .coef_rd(coef_rd), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [16];
    always @(posedge clk) if (coef_rd) coef_data <= rom[coef_addr];

    int checks = 0, errors = 0;
    int dcyc, n_rd, busy_cnt, busy_first, busy_last;
    int addr_log [32];
    logic [15:0] res_d, exp_res;
    logic        ovf_d, exp_ovf;

    task automatic model(input int n, input logic [15:0] xv);
        longint a = 0, p, s;
        bit ov = 0;
        for (int i = n; i >= 0; i--) begin
            p = a * longint'(xv);
            if ((p >> 16) != 0) ov = 1;
            s = (p & 64'hFFFF) + longint'(rom[i]);
            if (s > 64'hFFFF) ov = 1;
            a = s & 64'hFFFF;
        end
        exp_res = a[15:0];
`ifdef HORNER_OVERFLOW_DETECT_EN
        exp_ovf = ov;
`else
        exp_ovf = 1'b0;
`endif
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    endtask

    task automatic run_eval(input logic [3:0] n, input logic [15:0] xv);
        @(negedge clk); degree = n; x = xv; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dcyc = -1; n_rd = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (coef_rd) begin
                if (n_rd < 32) addr_log[n_rd] = int'(coef_addr);
                n_rd++;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (done) begin
                dcyc = k; res_d = result; ovf_d = ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, coef_rd, coef_addr, result, ovf} !== 24'd0) begin errors++; $display("FAIL reset_held got %h want 0", {busy, done, coef_rd, coef_addr, result, ovf}); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, coef_rd, result, ovf} !== 20'd0) begin errors++; $display("FAIL reset_idle got %h want 0", {busy, done, coef_rd, result, ovf}); end
    endtask

    task automatic test_basic();
        fill_rom(); rom[0] = 16'd3; rom[1] = 16'd2; rom[2] = 16'd1;
        model(2, 16'd5);
        run_eval(4'd2, 16'd5);
        checks++; if (dcyc !== 7) begin errors++; $display("FAIL basic_latency got %0d want 7", dcyc); end
        checks++; if (res_d !== 16'd38) begin errors++; $display("FAIL basic_result got %0d want 38", res_d); end
        checks++; if (ovf_d !== exp_ovf) begin errors++; $display("FAIL basic_ovf got %b want %b", ovf_d, exp_ovf); end
        checks++; if (n_rd !== 3) begin errors++; $display("FAIL basic_reads got %0d want 3", n_rd); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (addr_log[i] !== 2 - i) begin errors++; $display("FAIL basic_addr%0d got %0d want %0d", i, addr_log[i], 2 - i); end
        end
        checks++; if (busy_cnt !== 6 || busy_first !== 1 || busy_last !== 6) begin errors++; $display("FAIL basic_busy got cnt=%0d first=%0d last=%0d want 6/1/6", busy_cnt, busy_first, busy_last); end
    endtask

    task automatic test_degree_zero();
        rom[0] = 16'h1234;
        run_eval(4'd0, 16'hFFFF);
        checks++; if (dcyc !== 3) begin errors++; $display("FAIL deg0_latency got %0d want 3", dcyc); end
        checks++; if (res_d !== 16'h1234) begin errors++; $display("FAIL deg0_result got %h want 1234", res_d); end
        checks++; if (n_rd !== 1) begin errors++; $display("FAIL deg0_reads got %0d want 1", n_rd); end
        repeat (4) @(negedge clk);
        checks++; if (result !== 16'h1234) begin errors++; $display("FAIL deg0_hold got %h want 1234", result); end
    endtask

    task automatic test_wrap();
        rom[2] = 16'd1; rom[1] = 16'd0; rom[0] = 16'd0;
        model(2, 16'h0100);
        run_eval(4'd2, 16'h0100);
        checks++; if (res_d !== 16'h0000) begin errors++; $display("FAIL wrap_result got %h want 0000", res_d); end
        checks++; if (ovf_d !== exp_ovf) begin errors++; $display("FAIL wrap_ovf got %b want %b", ovf_d, exp_ovf); end
    endtask

    task automatic test_start_busy();
        int nd = 0;
        rom[0] = 16'd3; rom[1] = 16'd2; rom[2] = 16'd1;
        @(negedge clk); degree = 4'd2; x = 16'd5; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) nd++;
            start = (k == 3);
            if (k == 3) begin degree = 4'd7; x = 16'd9; end
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_dones got %0d want 1", nd); end
        checks++; if (result !== 16'd38) begin errors++; $display("FAIL busy_start_result got %0d want 38", result); end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        @(negedge clk); degree = 4'd2; x = 16'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({busy, done, coef_rd, coef_addr, result, ovf} !== 24'd0) begin errors++; $display("FAIL midreset_clear got %h want 0", {busy, done, coef_rd, coef_addr, result, ovf}); end
        @(negedge clk); reset = 1'b1;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_spurious_done got %0d want 0", nd); end
        run_eval(4'd2, 16'd5);
        checks++; if (res_d !== 16'd38 || dcyc !== 7) begin errors++; $display("FAIL midreset_rerun got %0d@%0d want 38@7", res_d, dcyc); end
    endtask

    task automatic test_back_to_back();
        int dc [8];
        int nd = 0;
        rom[1] = 16'd1; rom[0] = 16'd7;
        @(negedge clk); degree = 4'd1; x = 16'd2; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done && nd < 8) begin
                dc[nd] = k; nd++;
                checks++; if (result !== 16'd9) begin errors++; $display("FAIL b2b_result%0d got %0d want 9", nd, result); end
            end
        end
        start = 1'b0;
        checks++; if (nd < 3 || dc[0] !== 5) begin errors++; $display("FAIL b2b_first got n=%0d first=%0d want >=3 first=5", nd, dc[0]); end
        for (int i = 1; i < nd; i++) begin
            checks++; if (dc[i] - dc[i-1] !== 6) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 6", i, dc[i] - dc[i-1]); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            logic [3:0]  n;
            logic [15:0] xv;
            fill_rom();
            n  = 4'($urandom_range(0, 15));
            xv = 16'($urandom);
            model(int'(n), xv);
            run_eval(n, xv);
            checks++; if (res_d !== exp_res) begin errors++; $display("FAIL rand%0d_result got %h want %h", t, res_d, exp_res); end
            checks++; if (ovf_d !== exp_ovf) begin errors++; $display("FAIL rand%0d_ovf got %b want %b", t, ovf_d, exp_ovf); end
            checks++; if (dcyc !== 2 * (int'(n) + 1) + 1) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", t, dcyc, 2 * (int'(n) + 1) + 1); end
            checks++; if (n_rd !== int'(n) + 1 || addr_log[0] !== int'(n) || addr_log[n] !== 0) begin errors++; $display("FAIL rand%0d_addr got reads=%0d first=%0d last=%0d want %0d/%0d/0", t, n_rd, addr_log[0], addr_log[n], int'(n) + 1, n); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_degree_zero();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/horner_evaluator.md
Name: horner_evaluator

Overview:
- Sequential polynomial evaluator, p(x) = c[n]·x^n + … + c[0], using Horner's rule: acc ← acc·x + c[i], for i = n down to 0.
- Sits directly downstream of the coefficient-index counting stage.
  - Internally it owns its own down-counting index.
  - It drives the address of an external synchronous coefficient ROM and consumes the returned data.
- Start/busy/done handshake to the top-level controller. The result is held until the next evaluation completes.

Parameters:
- DATA_W, 16, width of x, coefficients, accumulator and result (unsigned, modulo 2^DATA_W).
- DEG_W, 4, width of degree and coefficient address; max degree 2^DEG_W − 1.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request evaluation; sampled only in IDLE
- degree  input  DEG_W  polynomial degree n; latched on accepted start
- x  input  DATA_W  evaluation point; latched on accepted start
- coef_rd  output  1  ROM read strobe
- coef_addr  output  DEG_W  ROM address (coefficient index i)
- coef_data  input  DATA_W  ROM data, valid exactly 1 cycle after coef_rd
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result valid
- result  output  DATA_W  final p(x); held until next done
- ovf  output  1  overflow flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - State → IDLE.
  - busy, done, coef_rd, coef_addr, result, ovf, internal acc, x_q, idx all cleared to 0.
  - Takes effect immediately, including mid-evaluation. The in-flight evaluation is abandoned and no done pulse is issued.
- States: IDLE, FETCH, MAC, DONE. Encoding is 2 bits, from the package.
- IDLE:
  - If start=1 at a clock edge: latch x_q←x, idx←degree, acc←0, state→FETCH.
  - Otherwise remain in IDLE.
- FETCH: coef_rd=1 and coef_addr=idx (registered outputs presented during this state); next state is MAC.
- MAC:
  - coef_rd=0.
  - acc ← (acc·x_q + coef_data) mod 2^DATA_W. The product is truncated to the low DATA_W bits before the add, and the sum is truncated as well.
  - If idx==0, next state is DONE. Otherwise idx←idx−1 and next state is FETCH.
- DONE: result←acc, done=1 for exactly this cycle, busy=0, next state is IDLE.
- busy=1 in FETCH and MAC only.
- Latency: start accepted at edge T0; done is high in cycle 2(n+1)+1 after T0. Examples: n=0 → cycle 3, n=15 → cycle 33.
- After DONE, a new start is accepted at the next edge (the IDLE cycle). Minimum spacing between evaluations is therefore 2(n+1)+2 cycles.
- start while busy or in DONE: ignored, with no side effects. degree/x changes while busy have no effect.
- Addresses issued strictly descending n, n−1, …, 0; each index is read exactly once.
- degree=0: a single FETCH/MAC pair, result = c[0].
- result is not cleared on start. It changes only in DONE (or on reset).

Optional Feature:
- Macro: HORNER_OVERFLOW_DETECT_EN.
- Defined:
  - ovf is sticky and is set in MAC if either the full 2·DATA_W-bit product acc·x_q has any nonzero bit above DATA_W−1, or the truncated add carries out.
  - ovf is cleared on accepted start and on reset, and is valid alongside done.
- Undefined: the detection logic is removed and ovf is tied to 0. The port remains present so the interface is identical.

Decomposition:
- Package poly_eval_pkg:
  - State encodings ST_IDLE=2'd0, ST_FETCH=2'd1, ST_MAC=2'd2, ST_DONE=2'd3.
  - Default widths DATA_W_DEF=16, DEG_W_DEF=4.
- One sub-module, horner_mac:
  - Combinational DATA_W step: next_acc = acc·x + c, truncated.
  - Provides an ovf_step output, present under HORNER_OVERFLOW_DETECT_EN.
- FSM, index register and handshake live in horner_evaluator.

Test Plan:
- Basic evaluation: ROM c0=3, c1=2, c2=1; degree=2, x=5, start pulse → coef_addr sequence 2,1,0; done high cycle 7 after accept; result=38; busy high cycles 1–6.
- Degree zero: c0=16'h1234, degree=0, x=16'hFFFF → done at cycle 3; result=16'h1234; exactly one coef_rd.
- Wrap-around: c2=1, c1=0, c0=0, degree=2, x=16'h0100 → result=16'h0000; ovf=1 with HORNER_OVERFLOW_DETECT_EN defined, ovf=0 otherwise.
- Start while busy: second start at cycle 3 with different x/degree → ignored; first result unchanged (38 for the basic case); only one done pulse.
- Reset mid-operation: assert reset in cycle 4 of the basic case → busy, done, coef_rd, result immediately 0; after release, no done until a new start; rerun gives 38.
- Back-to-back: start held high continuously, degree=1, c1=1, c0=7, x=2 → result=9 on each done; consecutive dones exactly 2(1+1)+2 = 6 cycles apart.
